// File: rtl/rdyacpt_rr_arb.sv
// Round-robin arbiter sharing one ready/accept downstream channel between
// NUM_REQ requesters, holding each grant for at most BURST beats.
module rdyacpt_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int BURST   = 4,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BCW    = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_rdy,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_acpt,
    output logic                     downstream_rdy,
    output logic [WIDTH-1:0]         downstream_data,
    input  logic                     downstream_acpt,
    output logic                     grant_valid,
    output logic [IDW-1:0]           grant_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;

    logic [WIDTH-1:0] req_word [NUM_REQ];
    logic             in_grant;
    logic             xfer;
    logic             last_beat;
    logic [IDW-1:0]   next_ptr;
    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic [IDW:0]     cand;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_word[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Scan from rr_ptr upward with wrap; descending loop so the nearest hit wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (req_rdy[cand[IDW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDW-1:0];
            end
        end
    end

    assign in_grant  = (state_q == GRANT);
    assign xfer      = downstream_rdy & downstream_acpt;
    assign last_beat = (beat_cnt_q == BCW'(BURST - 1));
    assign next_ptr  = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

    always_comb begin
        downstream_rdy  = 1'b0;
        downstream_data = '0;
        req_acpt        = '0;
        if (in_grant) begin
            downstream_rdy       = req_rdy[grant_id_q];
            downstream_data      = req_word[grant_id_q];
            req_acpt[grant_id_q] = downstream_acpt;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d       = GRANT;
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick_idx;
                    beat_cnt_d    = '0;
                end
            end
            GRANT: begin
                // Release after the BURST-th beat, or as soon as the holder goes idle.
                if ((xfer && last_beat) || !req_rdy[grant_id_q]) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = next_ptr;
                    beat_cnt_d    = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_rdyacpt_rr_arb.sv
// Randomised and directed bench for rdyacpt_rr_arb against a transaction-level
// model of grants, beats and the round-robin pointer.
module tb_rdyacpt_rr_arb;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int BURST   = 4;
    localparam int IDW     = 2;

    logic                     clk;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req_rdy;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_acpt;
    logic                     downstream_rdy;
    logic [WIDTH-1:0]         downstream_data;
    logic                     downstream_acpt;
    logic                     grant_valid;
    logic [IDW-1:0]           grant_id;

    rdyacpt_rr_arb #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_rdy         (req_rdy),
        .req_data        (req_data),
        .req_acpt        (req_acpt),
        .downstream_rdy  (downstream_rdy),
        .downstream_data (downstream_data),
        .downstream_acpt (downstream_acpt),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who holds the grant, how many beats it has moved, and
    // where the next search starts.
    bit m_busy;
    int m_gid;
    int m_beats;
    int m_ptr;
    int src_cnt [NUM_REQ];

    int grant_log [$];
    bit prev_gv;
    int xfer_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] lane_value(input int i);
        return WIDTH'((i * 64 + src_cnt[i]) & 255);
    endfunction

    task automatic applyStimulus(input logic [NUM_REQ-1:0] rdy, input logic acpt);
        req_rdy         = rdy;
        downstream_acpt = acpt;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = lane_value(i);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_gid   = 0;
        m_beats = 0;
        m_ptr   = 0;
        prev_gv = 1'b0;
        grant_log.delete();
    endtask

    // Asynchronous reset: outputs must drop before any clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        checkOutput("rst_gv", 32'(grant_valid), 32'd0);
        checkOutput("rst_drdy", 32'(downstream_rdy), 32'd0);
        checkOutput("rst_acpt", 32'(req_acpt), 32'd0);
        checkOutput("rst_data", 32'(downstream_data), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_gv_hold", 32'(grant_valid), 32'd0);
        reset_n = 1'b1;
    endtask

    // One clock cycle: drive, compare against the model, advance both at the edge.
    task automatic run_cycle(input logic [NUM_REQ-1:0] rdy, input logic acpt);
        logic             exp_rdy;
        logic [WIDTH-1:0] exp_data;
        logic [NUM_REQ-1:0] exp_acpt;
        applyStimulus(rdy, acpt);
        #1;
        exp_rdy  = 1'b0;
        exp_data = '0;
        exp_acpt = '0;
        if (m_busy) begin
            exp_rdy         = rdy[m_gid];
            exp_data        = lane_value(m_gid);
            exp_acpt[m_gid] = acpt;
        end
        checkOutput("grant_valid", 32'(grant_valid), 32'(m_busy));
        if (m_busy) checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
        checkOutput("ds_rdy", 32'(downstream_rdy), 32'(exp_rdy));
        checkOutput("ds_data", 32'(downstream_data), 32'(exp_data));
        checkOutput("req_acpt", 32'(req_acpt), 32'(exp_acpt));
        if (downstream_rdy && acpt) xfer_cnt++;

        if (!m_busy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!m_busy && rdy[(m_ptr + k) % NUM_REQ]) begin
                    m_busy  = 1'b1;
                    m_gid   = (m_ptr + k) % NUM_REQ;
                    m_beats = 0;
                end
            end
        end else if (rdy[m_gid] && acpt) begin
            src_cnt[m_gid]++;
            m_beats++;
            if (m_beats == BURST) begin
                m_busy  = 1'b0;
                m_ptr   = (m_gid + 1) % NUM_REQ;
                m_beats = 0;
            end
        end else if (!rdy[m_gid]) begin
            m_busy  = 1'b0;
            m_ptr   = (m_gid + 1) % NUM_REQ;
            m_beats = 0;
        end

        @(posedge clk);
        #1;
        if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_id));
        prev_gv = grant_valid;
    endtask

    function automatic int log_at(input int k);
        return (grant_log.size() > k) ? grant_log[k] : 99;
    endfunction

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) src_cnt[i] = 0;
        applyStimulus('0, 1'b0);
        xfer_cnt = 0;
        #2;
        do_reset();

        // Single requester: grant 1, four beats, one idle cycle, grant 1 again.
        for (int c = 0; c < 12; c++) run_cycle(4'b0010, 1'b1);
        checkOutput("single_g0", 32'(log_at(0)), 32'd1);
        checkOutput("single_g1", 32'(log_at(1)), 32'd1);

        // All requesting: rotation 0,1,2,3,0.
        do_reset();
        for (int c = 0; c < 22; c++) run_cycle(4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) checkOutput($sformatf("order%0d", k), 32'(log_at(k)), 32'(k % NUM_REQ));

        // Backpressure on requester 2: three stalled cycles, still exactly four beats.
        do_reset();
        xfer_cnt = 0;
        run_cycle(4'b0100, 1'b1);
        run_cycle(4'b0100, 1'b1);
        run_cycle(4'b0100, 1'b1);
        for (int c = 0; c < 3; c++) run_cycle(4'b0100, 1'b0);
        run_cycle(4'b0100, 1'b1);
        run_cycle(4'b0100, 1'b1);
        for (int c = 0; c < 3; c++) run_cycle(4'b0000, 1'b1);
        checkOutput("bp_beats", 32'(xfer_cnt), 32'd4);
        checkOutput("bp_grant", 32'(log_at(0)), 32'd2);
        checkOutput("bp_ngrants", 32'(grant_log.size()), 32'd1);

        // Early release: requester 0 drops after two beats, requester 1 follows.
        do_reset();
        for (int c = 0; c < 3; c++) run_cycle(4'b0011, 1'b1);
        for (int c = 0; c < 3; c++) run_cycle(4'b0010, 1'b1);
        checkOutput("early_g0", 32'(log_at(0)), 32'd0);
        checkOutput("early_g1", 32'(log_at(1)), 32'd1);

        // Wrap: after granting 2 the pointer sits at 3, so requester 0 wins by wrap.
        do_reset();
        for (int c = 0; c < 5; c++) run_cycle(4'b0100, 1'b1);
        for (int c = 0; c < 3; c++) run_cycle(4'b0001, 1'b1);
        checkOutput("wrap_g0", 32'(log_at(0)), 32'd2);
        checkOutput("wrap_g1", 32'(log_at(1)), 32'd0);

        // Reset during beat 2 of the grant to 3, then restart from requester 0.
        do_reset();
        for (int c = 0; c < 18; c++) run_cycle(4'b1111, 1'b1);
        checkOutput("midrst_pre", 32'(log_at(3)), 32'd3);
        do_reset();
        for (int c = 0; c < 3; c++) run_cycle(4'b1111, 1'b1);
        checkOutput("midrst_post", 32'(log_at(0)), 32'd0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [NUM_REQ-1:0] r;
            for (int i = 0; i < NUM_REQ; i++) r[i] = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 499) == 0) do_reset();
            run_cycle(r, ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
